// File: rtl/cpu_pkg.sv
// Shared constants and enumerations for the SimpleCPU execution datapath.
// Optional feature macro: CPU_DMEM_OUT_PORT_EN (memory-mapped output port at 8'hFF).
package cpu_pkg;

   localparam int DW       = 8;
   localparam int RF_AW    = 4;
   localparam int DM_AW    = 8;
   localparam int RF_DEPTH = 1 << RF_AW;
   localparam int DM_DEPTH = 1 << DM_AW;

   // Store to this address also updates the output port when the feature is built in.
   localparam logic [DM_AW-1:0] OUT_PORT_ADDR = 8'hFF;

   typedef enum logic {
      ALU_ADD = 1'b0,
      ALU_SUB = 1'b1
   } alu_op_e;

   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_EXT  = 2'd2,
      WB_CONS = 2'd3
   } wb_sel_e;

   // Write-back source decode: constant beats external input beats memory beats ALU.
   function automatic wb_sel_e wb_select(input logic rf_cons, input logic rf_ext,
                                         input logic rf_s);
      wb_sel_e sel;
      if (rf_cons)     sel = WB_CONS;
      else if (rf_ext) sel = WB_EXT;
      else if (rf_s)   sel = WB_MEM;
      else             sel = WB_ALU;
      return sel;
   endfunction

endpackage

// File: rtl/cpu_datapath_if.sv
// Strobe/data bundle between the SimpleCPU control unit (master) and the datapath (slave).
// Optional feature macro: CPU_DMEM_OUT_PORT_EN adds the out_port signal.
interface cpu_datapath_if;
   import cpu_pkg::*;

   logic [DM_AW-1:0] D_addr;
   logic             D_rd;
   logic             D_wr;
   logic             RF_s;
   logic [DW-1:0]    Val_cons;
   logic             RF_cons;
   logic             RF_ext;
   logic [DW-1:0]    ext_in;
   logic [RF_AW-1:0] RF_W_addr;
   logic             RF_W_wr;
   logic [RF_AW-1:0] RF_Rp_addr;
   logic             RF_Rp_rd;
   logic [RF_AW-1:0] RF_Rq_addr;
   logic             RF_Rq_rd;
   logic             alu_s0;
   logic             RF_Rp_zero;
`ifdef CPU_DMEM_OUT_PORT_EN
   logic [DW-1:0]    out_port;

   modport master (
      output D_addr, D_rd, D_wr, RF_s, Val_cons, RF_cons, RF_ext, ext_in,
             RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
      input  RF_Rp_zero, out_port
   );

   modport slave (
      input  D_addr, D_rd, D_wr, RF_s, Val_cons, RF_cons, RF_ext, ext_in,
             RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
      output RF_Rp_zero, out_port
   );
`else
   modport master (
      output D_addr, D_rd, D_wr, RF_s, Val_cons, RF_cons, RF_ext, ext_in,
             RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
      input  RF_Rp_zero
   );

   modport slave (
      input  D_addr, D_rd, D_wr, RF_s, Val_cons, RF_cons, RF_ext, ext_in,
             RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd, alu_s0,
      output RF_Rp_zero
   );
`endif

endinterface

// File: rtl/cpu_regfile.sv
// 16x8 register file: one synchronous write port, two combinational read ports.
// A disabled read port returns zero; reads see the pre-edge contents (no write bypass).
module cpu_regfile
   import cpu_pkg::*;
#(
   parameter int DW    = cpu_pkg::DW,
   parameter int RF_AW = cpu_pkg::RF_AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             w_wr,
   input  logic [RF_AW-1:0] w_addr,
   input  logic [DW-1:0]    w_data,
   input  logic [RF_AW-1:0] rp_addr,
   input  logic             rp_rd,
   output logic [DW-1:0]    rp_data,
   input  logic [RF_AW-1:0] rq_addr,
   input  logic             rq_rd,
   output logic [DW-1:0]    rq_data
);

   localparam int DEPTH = 1 << RF_AW;

   logic [DW-1:0] rf_q [DEPTH];
   logic [DW-1:0] rf_d [DEPTH];

   // Next-state register array: only the addressed entry changes on a write.
   always_comb begin
      rf_d = rf_q;
      if (w_wr) rf_d[w_addr] = w_data;
   end

   // Register update; reset clears every entry and drops a coincident write.
   always_ff @(posedge clk) begin
      if (rst) rf_q <= '{default: '0};
      else     rf_q <= rf_d;
   end

   assign rp_data = rp_rd ? rf_q[rp_addr] : '0;
   assign rq_data = rq_rd ? rf_q[rq_addr] : '0;

endmodule

// File: rtl/cpu_datapath.sv
// SimpleCPU execution datapath: register file, 8-bit add/sub ALU, 256x8 data memory
// and write-back source mux. Returns RF_Rp_zero to the control unit.
// Optional feature macro: CPU_DMEM_OUT_PORT_EN -- a store to 8'hFF also loads out_port.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int DW    = cpu_pkg::DW,
   parameter int RF_AW = cpu_pkg::RF_AW,
   parameter int DM_AW = cpu_pkg::DM_AW
) (
   input  logic          clk,
   input  logic          rst,
   cpu_datapath_if.slave bus
);

   localparam int DM_DEPTH_L = 1 << DM_AW;

   logic [DW-1:0]    rp_data;
   logic [DW-1:0]    rq_data;
   logic [DW-1:0]    alu_y;
   logic [DW-1:0]    mem_rdata;
   logic [DW-1:0]    wdata;
   alu_op_e          alu_op;
   wb_sel_e          wb_sel;

   logic [DW-1:0]    mem_q [DM_DEPTH_L];
   logic             mem_we_d;
   logic [DM_AW-1:0] mem_waddr_d;
   logic [DW-1:0]    mem_wdata_d;

   cpu_regfile #(
      .DW    (DW),
      .RF_AW (RF_AW)
   ) u_regfile (
      .clk     (clk),
      .rst     (rst),
      .w_wr    (bus.RF_W_wr),
      .w_addr  (bus.RF_W_addr),
      .w_data  (wdata),
      .rp_addr (bus.RF_Rp_addr),
      .rp_rd   (bus.RF_Rp_rd),
      .rp_data (rp_data),
      .rq_addr (bus.RF_Rq_addr),
      .rq_rd   (bus.RF_Rq_rd),
      .rq_data (rq_data)
   );

   assign alu_op = alu_op_e'(bus.alu_s0);
   assign wb_sel = wb_select(bus.RF_cons, bus.RF_ext, bus.RF_s);

   // ALU: modular add/sub, carry and borrow are simply dropped by the width.
   always_comb begin
      alu_y = '0;
      unique case (alu_op)
         ALU_ADD: alu_y = rp_data + rq_data;
         ALU_SUB: alu_y = rp_data - rq_data;
         default: alu_y = '0;
      endcase
   end

   // Load path is combinational so a load completes in the same cycle as its write-back.
   assign mem_rdata = bus.D_rd ? mem_q[bus.D_addr] : '0;

   // Write-back source mux.
   always_comb begin
      wdata = '0;
      unique case (wb_sel)
         WB_CONS: wdata = bus.Val_cons;
         WB_EXT:  wdata = bus.ext_in;
         WB_MEM:  wdata = mem_rdata;
         WB_ALU:  wdata = alu_y;
         default: wdata = '0;
      endcase
   end

   // Store request: Rp data into mem[D_addr]; reset suppresses the store, contents are kept.
   always_comb begin
      mem_we_d    = bus.D_wr & ~rst;
      mem_waddr_d = bus.D_addr;
      mem_wdata_d = rp_data;
   end

   // Data memory array, no reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (mem_we_d) mem_q[mem_waddr_d] <= mem_wdata_d;
   end

   assign bus.RF_Rp_zero = (rp_data == '0);

`ifdef CPU_DMEM_OUT_PORT_EN
   logic [DW-1:0] out_port_q;
   logic [DW-1:0] out_port_d;

   // Output port shadows stores to the top memory word and holds otherwise.
   always_comb begin
      out_port_d = out_port_q;
      if (bus.D_wr && (bus.D_addr == OUT_PORT_ADDR)) out_port_d = rp_data;
   end

   // Output port register with synchronous clear.
   always_ff @(posedge clk) begin
      if (rst) out_port_q <= '0;
      else     out_port_q <= out_port_d;
   end

   assign bus.out_port = out_port_q;
`endif

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed scenarios followed by random control
// strobes, checked against a word-level reference model of registers and memory.
// Build with CPU_DMEM_OUT_PORT_EN defined to also exercise the output port.
module tb_cpu_datapath;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [7:0] rf_m  [16];
   logic [7:0] mem_m [256];
   logic [7:0] out_m;

   cpu_datapath_if bus ();

   cpu_datapath dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic idle();
      bus.D_addr     = 8'h00;
      bus.D_rd       = 1'b0;
      bus.D_wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.Val_cons   = 8'h00;
      bus.RF_cons    = 1'b0;
      bus.RF_ext     = 1'b0;
      bus.ext_in     = 8'($urandom);
      bus.RF_W_addr  = 4'h0;
      bus.RF_W_wr    = 1'b0;
      bus.RF_Rp_addr = 4'h0;
      bus.RF_Rp_rd   = 1'b0;
      bus.RF_Rq_addr = 4'h0;
      bus.RF_Rq_rd   = 1'b0;
      bus.alu_s0     = 1'b0;
      rst            = 1'b0;
   endtask

   // One control-unit cycle: check outputs before the edge, then advance the model.
   task automatic tick(input string tag);
      logic [7:0] rp, rq, mrd, wd, alu;
      int         r;
      logic       do_rst, do_wr, do_st;
      logic [3:0] wa;
      logic [7:0] da;
      #1;
      rp  = bus.RF_Rp_rd ? rf_m[bus.RF_Rp_addr] : 8'h00;
      rq  = bus.RF_Rq_rd ? rf_m[bus.RF_Rq_addr] : 8'h00;
      mrd = bus.D_rd ? mem_m[bus.D_addr] : 8'h00;
      r   = bus.alu_s0 ? (int'(rp) - int'(rq)) : (int'(rp) + int'(rq));
      r   = ((r % 256) + 256) % 256;
      alu = 8'(r);
      if (bus.RF_cons)     wd = bus.Val_cons;
      else if (bus.RF_ext) wd = bus.ext_in;
      else if (bus.RF_s)   wd = mrd;
      else                 wd = alu;

      checks++;
      assert (bus.RF_Rp_zero === (rp == 8'h00))
      else begin
         errors++;
         $error("FAIL %s zero: observed %b expected %b", tag, bus.RF_Rp_zero, (rp == 8'h00));
      end
`ifdef CPU_DMEM_OUT_PORT_EN
      checks++;
      assert (bus.out_port === out_m)
      else begin
         errors++;
         $error("FAIL %s out_port: observed %h expected %h", tag, bus.out_port, out_m);
      end
`endif
      do_rst = rst;
      do_wr  = bus.RF_W_wr;
      do_st  = bus.D_wr;
      wa     = bus.RF_W_addr;
      da     = bus.D_addr;
      @(posedge clk);
      if (do_rst) begin
         foreach (rf_m[i]) rf_m[i] = 8'h00;
         out_m = 8'h00;
      end else begin
         if (do_wr) rf_m[wa] = wd;
         if (do_st) begin
            mem_m[da] = rp;
            if (da == 8'hFF) out_m = rp;
         end
      end
      @(negedge clk);
   endtask

   task automatic load_const(input logic [3:0] w, input logic [7:0] v);
      idle();
      bus.RF_cons = 1'b1; bus.Val_cons = v; bus.RF_W_addr = w; bus.RF_W_wr = 1'b1;
      tick("load_const");
   endtask

   task automatic alu_op(input logic [3:0] p, input logic [3:0] q, input logic sub,
                         input logic [3:0] w);
      idle();
      bus.RF_Rp_addr = p; bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = q; bus.RF_Rq_rd = 1'b1;
      bus.alu_s0 = sub; bus.RF_W_addr = w; bus.RF_W_wr = 1'b1;
      tick("alu_op");
   endtask

   task automatic read_p(input logic [3:0] p, input string tag);
      idle();
      bus.RF_Rp_addr = p; bus.RF_Rp_rd = 1'b1;
      tick(tag);
   endtask

   task automatic store(input logic [3:0] p, input logic [7:0] a);
      idle();
      bus.RF_Rp_addr = p; bus.RF_Rp_rd = 1'b1; bus.D_addr = a; bus.D_wr = 1'b1;
      tick("store");
   endtask

   task automatic load_mem(input logic [7:0] a, input logic [3:0] w);
      idle();
      bus.D_addr = a; bus.D_rd = 1'b1; bus.RF_s = 1'b1; bus.RF_W_addr = w; bus.RF_W_wr = 1'b1;
      tick("load_mem");
   endtask

   // Register value check through the zero flag: difference against a known constant.
   task automatic check_reg(input logic [3:0] a, input string tag);
      logic [3:0] s, d;
      s = a + 4'd1;
      d = a + 4'd2;
      load_const(s, rf_m[a]);
      alu_op(a, s, 1'b1, d);
      read_p(d, tag);
      if (rf_m[a] != 8'h00) read_p(a, tag);
   endtask

   initial begin
      idle();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      foreach (rf_m[i]) rf_m[i] = 8'h00;
      out_m = 8'h00;
      idle();

      // Reset state: every register reads zero.
      for (int i = 0; i < 16; i++) read_p(4'(i), "reset_rf");

      // Fill memory with zero via stores from a disabled read port.
      for (int i = 0; i < 256; i++) begin
         idle();
         bus.D_addr = 8'(i); bus.D_wr = 1'b1;
         tick("mem_init");
      end

      // Add wrap: 05 + FB = 00.
      load_const(4'd1, 8'h05);
      load_const(4'd2, 8'hFB);
      alu_op(4'd1, 4'd2, 1'b0, 4'd3);
      read_p(4'd3, "add_wrap");
      check_reg(4'd3, "add_wrap_val");

      // Subtract borrow wrap: 03 - 05 = FE.
      load_const(4'd1, 8'h03);
      load_const(4'd2, 8'h05);
      alu_op(4'd1, 4'd2, 1'b1, 4'd3);
      read_p(4'd3, "sub_wrap");
      check_reg(4'd3, "sub_wrap_val");

      // Store then load.
      load_const(4'd1, 8'h3C);
      store(4'd1, 8'h10);
      load_mem(8'h10, 4'd4);
      check_reg(4'd4, "store_load");

      // Same-cycle write/read of r5 returns the old value.
      load_const(4'd5, 8'h00);
      idle();
      bus.RF_cons = 1'b1; bus.Val_cons = 8'h07; bus.RF_W_addr = 4'd5; bus.RF_W_wr = 1'b1;
      bus.RF_Rp_addr = 4'd5; bus.RF_Rp_rd = 1'b1;
      tick("no_bypass");
      read_p(4'd5, "write_visible");

      // Reset drops a coincident register write and store.
      load_const(4'd6, 8'h11);
      idle();
      rst = 1'b1;
      bus.RF_Rp_addr = 4'd6; bus.RF_Rp_rd = 1'b1; bus.D_addr = 8'h20; bus.D_wr = 1'b1;
      bus.RF_cons = 1'b1; bus.Val_cons = 8'h22; bus.RF_W_addr = 4'd7; bus.RF_W_wr = 1'b1;
      tick("rst_prio");
      read_p(4'd7, "rst_drop_wr");
      load_mem(8'h20, 4'd8);
      read_p(4'd8, "rst_drop_st");

      // Write-back priority with all selects active.
      load_const(4'd9, 8'h44);
      store(4'd9, 8'h30);
      idle();
      bus.RF_cons = 1'b1; bus.Val_cons = 8'h00; bus.RF_ext = 1'b1; bus.ext_in = 8'h5A;
      bus.RF_s = 1'b1; bus.D_rd = 1'b1; bus.D_addr = 8'h30; bus.RF_W_addr = 4'd10; bus.RF_W_wr = 1'b1;
      tick("wb_prio_cons");
      read_p(4'd10, "wb_prio_cons_rd");
      idle();
      bus.RF_ext = 1'b1; bus.ext_in = 8'h00; bus.RF_s = 1'b1; bus.D_rd = 1'b1;
      bus.D_addr = 8'h30; bus.RF_W_addr = 4'd10; bus.RF_W_wr = 1'b1;
      tick("wb_prio_ext");
      read_p(4'd10, "wb_prio_ext_rd");

`ifdef CPU_DMEM_OUT_PORT_EN
      // Output port shadow of 8'hFF, cleared by reset while memory keeps the word.
      load_const(4'd1, 8'hA5);
      store(4'd1, 8'hFF);
      read_p(4'd0, "out_port_set");
      idle();
      rst = 1'b1;
      tick("out_port_rst");
      read_p(4'd0, "out_port_clr");
      load_mem(8'hFF, 4'd2);
      check_reg(4'd2, "mem_ff_kept");
`endif

      // Random control-unit traffic.
      for (int n = 0; n < 600; n++) begin
         bus.D_addr     = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
         bus.D_rd       = 1'($urandom);
         bus.D_wr       = ($urandom_range(0, 3) == 0);
         bus.RF_s       = 1'($urandom);
         bus.Val_cons   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
         bus.RF_cons    = ($urandom_range(0, 3) == 0);
         bus.RF_ext     = ($urandom_range(0, 3) == 0);
         bus.ext_in     = 8'($urandom);
         bus.RF_W_addr  = 4'($urandom);
         bus.RF_W_wr    = 1'($urandom);
         bus.RF_Rp_addr = 4'($urandom);
         bus.RF_Rp_rd   = ($urandom_range(0, 7) != 0);
         bus.RF_Rq_addr = 4'($urandom);
         bus.RF_Rq_rd   = ($urandom_range(0, 7) != 0);
         bus.alu_s0     = 1'($urandom);
         rst            = ($urandom_range(0, 63) == 0);
         tick("random");
      end

      // Final register contents.
      for (int i = 0; i < 16; i++) check_reg(4'(i), "final_reg");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
